// File: rtl/sw_alloc_first_arbiter.sv
// Input-side switch-allocator stage: per input port, round-robin VC pick feeding the output-side stage.
// Optional SW_ALLOC_FIRST_LOCK_EN holds an ungranted winner until it is granted or loses eligibility.

module sw_alloc_first_port #(
  parameter int VC_NUM_PER_PORT = 4,
  parameter int ARBITER_WIDTH   = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [VC_NUM_PER_PORT-1:0]                    req,
  input  logic [VC_NUM_PER_PORT-1:0][ARBITER_WIDTH-1:0] dest,
  input  logic [ARBITER_WIDTH-1:0]                      gnt_in,
  output logic [ARBITER_WIDTH-1:0]                      port_req,
  output logic [VC_NUM_PER_PORT-1:0]                    vc_gnt,
  output logic                                          any_gnt
);
  localparam int PW = (VC_NUM_PER_PORT > 1) ? $clog2(VC_NUM_PER_PORT) : 1;

  logic [PW-1:0]              rr_ptr, win, win_nxt;
  logic [VC_NUM_PER_PORT-1:0] elig;
  logic                       have_win;
  int                         idx;

`ifdef SW_ALLOC_FIRST_LOCK_EN
  logic          lock_valid;
  logic [PW-1:0] lock_vc;
`endif

  // A VC with no destination bit set cannot compete.
  always_comb
    for (int v = 0; v < VC_NUM_PER_PORT; v++)
      elig[v] = req[v] & (|dest[v]);

  always_comb begin
    win      = '0;
    have_win = 1'b0;
    idx      = 0;
    for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
      idx = (int'(rr_ptr) + i) % VC_NUM_PER_PORT;
      if (!have_win && elig[idx]) begin
        have_win = 1'b1;
        win      = PW'(idx);
      end
    end
`ifdef SW_ALLOC_FIRST_LOCK_EN
    // Keep the pending request stable toward the output stage.
    if (lock_valid && elig[lock_vc]) begin
      have_win = 1'b1;
      win      = lock_vc;
    end
`endif
  end

  assign port_req = (reset && have_win) ? dest[win] : '0;
  assign any_gnt  = |(gnt_in & port_req);
  assign vc_gnt   = any_gnt ? (VC_NUM_PER_PORT'(1) << win) : '0;
  assign win_nxt  = (int'(win) == VC_NUM_PER_PORT-1) ? '0 : win + PW'(1);

  always_ff @(posedge clk or negedge reset)
    if (!reset)       rr_ptr <= '0;
    else if (any_gnt) rr_ptr <= win_nxt;

`ifdef SW_ALLOC_FIRST_LOCK_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lock_valid <= 1'b0;
      lock_vc    <= '0;
    end else if (have_win && !any_gnt) begin
      lock_valid <= 1'b1;
      lock_vc    <= win;
    end else begin
      lock_valid <= 1'b0;
    end
`endif

  for (genvar v = 0; v < VC_NUM_PER_PORT; v++) begin : g_chk
    a_dest_onehot: assert property (@(posedge clk) disable iff (!reset)
      req[v] |-> $onehot0(dest[v]));
  end
endmodule

module sw_alloc_first_arbiter #(
  parameter int VC_NUM_PER_PORT = 4,
  parameter int PORT_NUM        = 5,
  parameter int ARBITER_WIDTH   = PORT_NUM-1,
  parameter int PORT_REQ_WIDTH  = PORT_NUM*ARBITER_WIDTH,
  parameter int VC_ALL          = PORT_NUM*VC_NUM_PER_PORT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [VC_ALL-1:0]               vc_requests,
  input  logic [VC_ALL*ARBITER_WIDTH-1:0] vc_dest_port,
  input  logic [PORT_REQ_WIDTH-1:0]       port_granted,
  output logic [PORT_REQ_WIDTH-1:0]       port_requests,
  output logic [VC_ALL-1:0]               vc_granted,
  output logic [PORT_NUM-1:0]             any_vc_granted
);
  logic [PORT_NUM-1:0][VC_NUM_PER_PORT-1:0][ARBITER_WIDTH-1:0] dest_p;
  logic [PORT_NUM-1:0][ARBITER_WIDTH-1:0]                      req_p, gnt_p;
  logic [PORT_NUM-1:0][VC_NUM_PER_PORT-1:0]                    vreq_p, vgnt_p;

  assign dest_p        = vc_dest_port;
  assign vreq_p        = vc_requests;
  assign gnt_p         = port_granted;
  assign port_requests = req_p;
  assign vc_granted    = vgnt_p;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    sw_alloc_first_port #(
      .VC_NUM_PER_PORT (VC_NUM_PER_PORT),
      .ARBITER_WIDTH   (ARBITER_WIDTH)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .req      (vreq_p[p]),
      .dest     (dest_p[p]),
      .gnt_in   (gnt_p[p]),
      .port_req (req_p[p]),
      .vc_gnt   (vgnt_p[p]),
      .any_gnt  (any_vc_granted[p])
    );
  end
endmodule

// File: doc/sw_alloc_first_arbiter.md
Name: sw_alloc_first_arbiter

Overview:
First (input-side) stage of the VC-based mesh router switch allocator.
- For every input port, picks one VC from the VCs that currently request the crossbar, using round-robin.
- Forwards the winner's one-hot output-port request to the second (output-side) arbitration stage.
- Uses the second stage's grants to produce per-VC grants and to advance its round-robin pointers.
- Its port_requests / port_granted vectors use the packed, own-port-excluded layout the second stage consumes and produces.

Parameters:
VC_NUM_PER_PORT, 4, VCs per input port.
PORT_NUM, 5, router ports.
ARBITER_WIDTH, PORT_NUM-1, destinations per input port; a port never requests itself.
PORT_REQ_WIDTH, PORT_NUM*ARBITER_WIDTH, width of packed port request/grant vectors.
VC_ALL, PORT_NUM*VC_NUM_PER_PORT, total VCs.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
vc_requests  input  VC_ALL  bit p*VC_NUM_PER_PORT+v: VC v of input port p has an eligible flit (buffer non-empty, credit available).
vc_dest_port  input  VC_ALL*ARBITER_WIDTH  slice (p*VC_NUM_PER_PORT+v)*ARBITER_WIDTH +: ARBITER_WIDTH: one-hot relative destination of that VC.
port_granted  input  PORT_REQ_WIDTH  second-stage grants, same layout as port_requests.
port_requests  output  PORT_REQ_WIDTH  slice p*ARBITER_WIDTH +: ARBITER_WIDTH: destination request of input port p's winning VC.
vc_granted  output  VC_ALL  one-hot per port: VC that wins the switch this cycle.
any_vc_granted  output  PORT_NUM  OR of each port's vc_granted slice.

Behaviour:
- Relative destination encoding for input port p, bit k: output k if k<p, output k+1 if k>=p.
- Per-port state: rr_ptr, log2(VC_NUM_PER_PORT) bits, reset to 0.
- Eligibility: VC v is eligible when vc_requests bit = 1 and its dest slice is non-zero. A zero dest slice masks the request. A multi-hot dest slice is illegal; a simulation assertion flags it.
- Selection is combinational, zero latency:
  - Scan eligible VCs starting at rr_ptr, ascending, wrapping VC_NUM_PER_PORT-1 -> 0.
  - First hit is the winner.
  - port_requests slice = winner's dest slice; all zeros if no eligible VC.
- Grant is combinational, same cycle:
  - port_granted slice = the bits of port_granted at the same positions as port p's port_requests slice.
  - vc_granted slice = winner one-hot AND (OR of that port_granted slice).
  - any_vc_granted[p] = that OR.
  - Any port_granted bit that is not in the port's current request is ignored.
- Pointer update, at the clock edge:
  - If any_vc_granted[p]: rr_ptr <= (winner+1) mod VC_NUM_PER_PORT.
  - Otherwise: hold.
  - A winner of VC_NUM_PER_PORT-1 wraps the pointer to 0.
- Ports are fully independent; no cross-port state.
- Reset asserted, including mid-operation:
  - All pointers, and lock state if compiled in, go to 0 asynchronously.
  - port_requests, vc_granted and any_vc_granted are forced to 0 while reset=0.
  - Normal operation resumes on the first clock edge after deassertion, with pointers at 0.
- Simultaneous events: a VC that drops its request in the same cycle it is granted still gets the grant. Upstream must not deassert a request combinationally on grant.
- All outputs are combinational from inputs and state; no output register.

Optional Feature:
SW_ALLOC_FIRST_LOCK_EN
- Defined:
  - Adds per-port registers lock_valid (1 bit) and lock_vc.
  - When port p's winner is not granted: lock_valid <= 1 and lock_vc <= winner.
  - While lock_valid = 1 and lock_vc remains eligible, lock_vc is forced as winner regardless of rr_ptr. A newly eligible, earlier-priority VC cannot displace the pending request, so requests stay stable toward the second stage.
  - The lock clears on a grant (pointer then updates as normal) or when lock_vc becomes ineligible; in that case normal round-robin selection applies in the same cycle.
- Undefined: no lock registers; the winner is re-selected every cycle from rr_ptr.

Test Plan:
1. Reset held low for 3 cycles, all inputs 1 -> every output 0. After release, with no requests -> port_requests = 0.
2. Port 1: VC0 and VC2 request, dest = output 3 (rel bit 2), no grant -> port_requests[6] = 1, vc_granted = 0, rr_ptr stays 0.
3. As in 2, plus port_granted[6] = 1 for one cycle -> vc_granted[4] = 1, any_vc_granted[1] = 1. Next cycle winner is VC2: port_requests[6] = 1, and port_granted[6] = 1 gives vc_granted[6] = 1.
4. Port 0, all 4 VCs request, dest = output 4 (rel bit 3), grant held every cycle -> vc_granted[3:0] = 0001, 0010, 0100, 1000, 0001 (wrap).
5. Port 2: VC1 requests with a zero dest slice and VC3 with rel bit 0 -> port_requests[8] = 1 and VC1 is never granted. A stray port_granted[9] = 1 -> no vc_granted.
6. LOCK_EN: port 3, VC2 wins and is not granted; then VC0 requests with rr_ptr = 0 -> VC2 stays winner until granted. Without LOCK_EN, VC0 wins.
